ir_scan_ctrl: RTL
=================

IR_SCAN_CTRL -- requirements
Module: ir_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, 8, number of IR channels scanned per frame; legal 2..8.
REQ-002 Parameter RES_W, 12, A2D result width.
REQ-003 Parameter PERIOD_CYC, 262144, clk cycles spent in WAIT_TMR between frames; legal >=2.
REQ-004 Parameter SETTLE_CYC, 4096, clk cycles IR emitters are on before the first conversion; legal >=2.
REQ-005 Derived CH_W = max(1, clog2(NUM_CH)).
REQ-006 Reset rst_n, asynchronous, active-low; clock clk.
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 en  in  1  scan enable; low aborts any frame.
REQ-010 one_shot  in  1  1: frame starts only on trig; 0: free-running frames.
REQ-011 trig  in  1  single-cycle frame request, used only when one_shot=1.
REQ-012 thres  in  RES_W  line-detect threshold, sampled when IR_vld is generated.
REQ-013 cnv_cmplt  in  1  A2D conversion-done pulse.
REQ-014 res  in  RES_W  A2D result, valid while cnv_cmplt=1.
REQ-015 strt_cnv  out  1  A2D start pulse.
REQ-016 chnnl  out  CH_W  channel being converted.
REQ-017 IR_en  out  1  IR emitter enable.
REQ-018 ir_data  out  NUM_CH*RES_W  packed results; channel k at bits [k*RES_W +: RES_W].
REQ-019 IR_vld  out  1  one-cycle frame-complete pulse.
REQ-020 line_present  out  1  frame maximum strictly exceeds thres.
REQ-021 max_val  out  RES_W  largest result of the last complete frame.
REQ-022 max_idx  out  CH_W  channel holding max_val.

Function
REQ-023 FSM states SHALL be IDLE, WAIT_TMR, SETTLE, START, WAIT_CNV; the IDLE timer and channel counter SHALL clear.
REQ-024 IDLE: en=1 and one_shot=0 SHALL move to WAIT_TMR; en=1, one_shot=1, trig=1 SHALL move directly to SETTLE; otherwise stay in IDLE.
REQ-025 WAIT_TMR SHALL last exactly PERIOD_CYC cycles, then move to SETTLE with the timer cleared.
REQ-026 SETTLE SHALL last exactly SETTLE_CYC cycles with IR_en=1, clear chnnl to 0, then move to START.
REQ-027 START SHALL last one cycle with strt_cnv=1 and IR_en=1, then move to WAIT_CNV.
REQ-028 WAIT_CNV SHALL hold IR_en=1 until cnv_cmplt; on cnv_cmplt, res SHALL be written to slot chnnl of ir_data, and chnnl SHALL increment.
REQ-029 If chnnl=NUM_CH-1 on that cnv_cmplt, the FSM SHALL move to IDLE with IR_en=0 in the IDLE cycle; otherwise it SHALL return to START.
REQ-030 The running maximum SHALL be clocked on clk only and SHALL clear in SETTLE; it updates on cnv_cmplt when res is strictly greater, so ties keep the lowest index.
REQ-031 IR_vld SHALL be a registered pulse exactly one cycle after the final cnv_cmplt.
REQ-032 max_val, max_idx and line_present (max > thres) SHALL all update on that same IR_vld cycle and hold otherwise.
REQ-033 en low in any non-IDLE state SHALL force IDLE on the next edge, with IR_en and strt_cnv low.
REQ-034 An abort SHALL NOT assert IR_vld and SHALL leave max_val, max_idx and line_present unchanged; ir_data slots already written keep their new values.
REQ-035 cnv_cmplt received outside WAIT_CNV SHALL be ignored.
REQ-036 trig received outside IDLE, or while one_shot=0, SHALL be ignored, not queued.
REQ-037 In free-running mode, a new WAIT_TMR SHALL begin in the cycle after IDLE.

Reset
REQ-038 On rst_n low, the FSM SHALL enter IDLE and all outputs, timer, chnnl, ir_data, max_val and max_idx SHALL be 0, immediately and asynchronously.
REQ-039 Reset mid-frame SHALL discard the frame; the first frame after reset SHALL start per REQ-024.

Verification (NUM_CH=8, PERIOD_CYC=16, SETTLE_CYC=4, RES_W=12, A2D model answers 10 cycles after strt_cnv)
REQ-040 Free-run, en=1, results 0x010,0x020,...,0x080 for ch0..7, thres=0x040 -> IR_en high 4 cycles before first strt_cnv, 8 strt_cnv pulses, IR_vld once, ir_data matches, max_val=0x080, max_idx=7, line_present=1.
REQ-041 All results 0x030, thres=0x040 -> max_val=0x030, max_idx=0, line_present=0; results 0x040 with thres=0x040 -> line_present=0.
REQ-042 one_shot=1, no trig for 100 cycles -> no strt_cnv; a single trig -> exactly one frame and IR_vld, then idle until the next trig.
REQ-043 en dropped during the ch3 conversion -> IR_en low next cycle, no IR_vld, previous max/line_present held; late cnv_cmplt ignored.
REQ-044 rst_n asserted in WAIT_CNV -> all outputs 0 immediately; after release, the full frame completes correctly.
REQ-045 NUM_CH=3 build -> chnnl sequence 0,1,2, IR_vld after the third cnv_cmplt, ir_data width 36.

Source files
------------

// File: rtl/ir_scan_ctrl_if.sv
// ir_scan_ctrl_if: control, A2D handshake and frame-result signals of the IR scan controller
interface ir_scan_ctrl_if #(
  parameter int NUM_CH = 8,
  parameter int RES_W  = 12
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  logic                    en;
  logic                    one_shot;
  logic                    trig;
  logic [RES_W-1:0]        thres;
  logic                    cnv_cmplt;
  logic [RES_W-1:0]        res;
  logic                    strt_cnv;
  logic [CH_W-1:0]         chnnl;
  logic                    IR_en;
  logic [NUM_CH*RES_W-1:0] ir_data;
  logic                    IR_vld;
  logic                    line_present;
  logic [RES_W-1:0]        max_val;
  logic [CH_W-1:0]         max_idx;
  modport master (
    output en, one_shot, trig, thres, cnv_cmplt, res,
    input  strt_cnv, chnnl, IR_en, ir_data, IR_vld, line_present, max_val, max_idx
  );
  modport slave (
    input  en, one_shot, trig, thres, cnv_cmplt, res,
    output strt_cnv, chnnl, IR_en, ir_data, IR_vld, line_present, max_val, max_idx
  );
endinterface

// File: rtl/ir_scan_ctrl.sv
// ir_scan_ctrl: sequences IR emitters and A2D conversions over all channels, tracking the frame maximum
module ir_scan_ctrl #(
  parameter int NUM_CH     = 8,
  parameter int RES_W      = 12,
  parameter int PERIOD_CYC = 262144,
  parameter int SETTLE_CYC = 4096
) (
  input logic          clk,
  input logic          rst_n,
  ir_scan_ctrl_if.slave bus
);
  localparam int CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int TMR_MAX = (PERIOD_CYC > SETTLE_CYC) ? PERIOD_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX);
  typedef enum logic [2:0] {IDLE, WAIT_TMR, SETTLE, START, WAIT_CNV} state_t;
  state_t                  r_state, w_nxt;
  logic [TMR_W-1:0]        r_tmr;
  logic [CH_W-1:0]         r_chnnl, r_run_idx, r_max_idx, w_idx;
  logic [RES_W-1:0]        r_run_max, r_max_val, w_max;
  logic [NUM_CH*RES_W-1:0] r_data;
  logic                    r_vld, r_line;
  logic                    w_cmplt, w_last, w_tmr_end, w_gt;
  assign w_cmplt   = r_state == WAIT_CNV && bus.en && bus.cnv_cmplt;
  assign w_last    = r_chnnl == CH_W'(NUM_CH - 1);
  assign w_tmr_end = r_tmr == TMR_W'(((r_state == WAIT_TMR) ? PERIOD_CYC : SETTLE_CYC) - 1);
  assign w_gt      = bus.res > r_run_max;
  assign w_max     = w_gt ? bus.res : r_run_max;
  assign w_idx     = w_gt ? r_chnnl : r_run_idx;
  assign bus.chnnl        = r_chnnl;
  assign bus.ir_data      = r_data;
  assign bus.IR_vld       = r_vld;
  assign bus.line_present = r_line;
  assign bus.max_val      = r_max_val;
  assign bus.max_idx      = r_max_idx;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  // next state and emitter/convert strobes; en low aborts from any state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     w_nxt = !bus.one_shot ? WAIT_TMR : bus.trig ? SETTLE : IDLE;
      WAIT_TMR: w_nxt = w_tmr_end ? SETTLE : WAIT_TMR;
      SETTLE:   w_nxt = w_tmr_end ? START : SETTLE;
      START:    w_nxt = WAIT_CNV;
      WAIT_CNV: w_nxt = !bus.cnv_cmplt ? WAIT_CNV : w_last ? IDLE : START;
      default:  w_nxt = IDLE;
    endcase
    if (!bus.en) w_nxt = IDLE;
    bus.strt_cnv = r_state == START;
    bus.IR_en    = r_state == SETTLE || r_state == START || r_state == WAIT_CNV;
  end
  // shared timer for WAIT_TMR and SETTLE, cleared on every state change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tmr <= '0;
    else        r_tmr <= (w_nxt == r_state && (r_state == WAIT_TMR || r_state == SETTLE)) ? r_tmr + 1'b1 : '0;
  // channel counter: restarts each frame, advances on each accepted conversion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                  r_chnnl <= '0;
    else if (r_state == IDLE || r_state == SETTLE) r_chnnl <= '0;
    else if (w_cmplt)                            r_chnnl <= w_last ? '0 : r_chnnl + 1'b1;
  // result slots: written as each conversion lands, kept across aborts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_data <= '0;
    else
      for (int k = 0; k < NUM_CH; k++)
        if (w_cmplt && r_chnnl == CH_W'(k)) r_data[k*RES_W +: RES_W] <= bus.res;
  // running maximum within the frame; strict compare keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_run_max <= '0;
      r_run_idx <= '0;
    end else if (r_state == SETTLE) begin
      r_run_max <= '0;
      r_run_idx <= '0;
    end else if (w_cmplt) begin
      r_run_max <= w_max;
      r_run_idx <= w_idx;
    end
  // frame-complete pulse and published results, only on a frame that finished
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vld     <= 1'b0;
      r_max_val <= '0;
      r_max_idx <= '0;
      r_line    <= 1'b0;
    end else begin
      r_vld <= w_cmplt && w_last;
      if (w_cmplt && w_last) begin
        r_max_val <= w_max;
        r_max_idx <= w_idx;
        r_line    <= w_max > bus.thres;
      end
    end
endmodule
